// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_sequencer_pkg                                             |
// | Description : Shared state encoding and table-select codes for the        |
// |               program-counter sequencer.                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic CFG_SEL_LUT   = 1'b0;
  localparam logic CFG_SEL_START = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pc_target_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_target_lut                                                |
// | Description : Jump-target table and program start-address table with one  |
// |               shared synchronous write port and two combinational reads.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pc_target_lut
  import pc_sequencer_pkg::*;
#(
  parameter int PC_BITS   = 12,
  parameter int NUM_PROGS = 3,
  parameter int LUT_DEPTH = 16,
  parameter int LUT_AW    = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1,
  parameter int PS_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic               sel_i,
  input  logic [LUT_AW-1:0]  waddr_i,
  input  logic [PC_BITS-1:0] wdata_i,
  input  logic [LUT_AW-1:0]  jmp_idx_i,
  output logic [PC_BITS-1:0] jmp_data_o,
  input  logic [PS_W-1:0]    start_idx_i,
  output logic [PC_BITS-1:0] start_data_o
);

  logic [PC_BITS-1:0] lut_q   [LUT_DEPTH];
  logic [PC_BITS-1:0] start_q [NUM_PROGS];

  // Jump LUT: written directly by index, cleared on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (we_i && (sel_i == CFG_SEL_LUT) && (int'(waddr_i) < LUT_DEPTH)) begin
      lut_q[waddr_i] <= wdata_i;
    end
  end

  // Start table: writes beyond the last program slot fall through untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NUM_PROGS; p++) start_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PROGS; p++) begin
        if (we_i && (sel_i == CFG_SEL_START) && (int'(waddr_i) == p)) begin
          start_q[p] <= wdata_i;
        end
      end
    end
  end

  assign jmp_data_o = lut_q[jmp_idx_i];

  // Start read: an out-of-range index yields 0 rather than an undefined value.
  always_comb begin
    start_data_o = '0;
    for (int p = 0; p < NUM_PROGS; p++) begin
      if (int'(start_idx_i) == p) start_data_o = start_q[p];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_sequencer                                                 |
// | Description : Multi-program fetch-address sequencer with start/done       |
// |               handshake, stall, halt and LUT-based abs/rel branches.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter  int PC_BITS   = 12,
  parameter  int NUM_PROGS = 3,
  parameter  int LUT_DEPTH = 16,
  parameter  int CNT_BITS  = 16,
  localparam int PS_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int LUT_AW    = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [PS_W-1:0]     prog_sel,
  input  logic                stall,
  input  logic                halt,
  input  logic                branch_taken,
  input  logic                branch_rel,
  input  logic [LUT_AW-1:0]   target_idx,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [LUT_AW-1:0]   cfg_addr,
  input  logic [PC_BITS-1:0]  cfg_data,
  output logic [PC_BITS-1:0]  pc_out,
  output logic                running,
  output logic                done,
  output logic                err,
  output logic [CNT_BITS-1:0] instr_count
);

  seq_state_t          state_q, state_d;
  logic [PC_BITS-1:0]  pc_q, pc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [PC_BITS-1:0]  jmp_data_w;
  logic [PC_BITS-1:0]  start_data_w;
  logic [CNT_BITS-1:0] cnt_inc_w;
  logic                prog_ok_w;

  pc_target_lut #(
    .PC_BITS   (PC_BITS),
    .NUM_PROGS (NUM_PROGS),
    .LUT_DEPTH (LUT_DEPTH),
    .LUT_AW    (LUT_AW),
    .PS_W      (PS_W)
  ) u_tables (
    .clk_i        (clock),
    .rst_i        (reset),
    .we_i         (cfg_we),
    .sel_i        (cfg_sel),
    .waddr_i      (cfg_addr),
    .wdata_i      (cfg_data),
    .jmp_idx_i    (target_idx),
    .jmp_data_o   (jmp_data_w),
    .start_idx_i  (prog_sel),
    .start_data_o (start_data_w)
  );

  assign prog_ok_w = (int'(prog_sel) < NUM_PROGS);
  // Retired-instruction counter sticks at all-ones instead of wrapping.
  assign cnt_inc_w = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(1);

  // State, PC, counter and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-PC selection; in RUN priority is halt > stall > branch > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (prog_ok_w) begin
            state_d = RUN;
            pc_d    = start_data_w;
            cnt_d   = '0;
            done_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DONE;
          done_d  = 1'b1;
          cnt_d   = cnt_inc_w;
        end else if (!stall) begin
          cnt_d = cnt_inc_w;
          if (branch_taken) begin
            // Relative offsets are two's-complement; the modular add handles sign.
            pc_d = branch_rel ? (pc_q + jmp_data_w) : jmp_data_w;
          end else begin
            pc_d = pc_q + PC_BITS'(1);
          end
        end
      end
      DONE: begin
        // Start must drop before a new run can be requested from IDLE.
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc_out      = pc_q;
  assign running     = (state_q == RUN);
  assign done        = done_q;
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_sequencer                                              |
// | Description : Directed self-checking bench for pc_sequencer with an        |
// |               expected-output scoreboard queue.                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  prog_sel = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic        branch_rel = 1'b0;
  logic [3:0]  target_idx = '0;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [11:0] cfg_data = '0;
  logic [11:0] pc_out;
  logic        running;
  logic        done;
  logic        err;
  logic [15:0] instr_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [11:0] pc;
    logic [15:0] cnt;
    logic        run;
    logic        dn;
    logic        er;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(
    .PC_BITS   (12),
    .NUM_PROGS (3),
    .LUT_DEPTH (16),
    .CNT_BITS  (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .prog_sel     (prog_sel),
    .stall        (stall),
    .halt         (halt),
    .branch_taken (branch_taken),
    .branch_rel   (branch_rel),
    .target_idx   (target_idx),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .pc_out       (pc_out),
    .running      (running),
    .done         (done),
    .err          (err),
    .instr_count  (instr_count)
  );

  always #5 clock = ~clock;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: bench did not reach its summary line");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic [11:0] pc, input logic [15:0] cnt,
                          input logic run, input logic dn, input logic er);
    exp_t e;
    e.tag = tag; e.pc = pc; e.cnt = cnt; e.run = run; e.dn = dn; e.er = er;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard: queue empty, got pc=%h", pc_out);
    end else begin
      e = sb.pop_front();
      tests++;
      assert (pc_out === e.pc) else begin
        fails++; $error("FAIL %s pc_out got %h exp %h", e.tag, pc_out, e.pc);
      end
      tests++;
      assert (instr_count === e.cnt) else begin
        fails++; $error("FAIL %s instr_count got %h exp %h", e.tag, instr_count, e.cnt);
      end
      tests++;
      assert (running === e.run) else begin
        fails++; $error("FAIL %s running got %b exp %b", e.tag, running, e.run);
      end
      tests++;
      assert (done === e.dn) else begin
        fails++; $error("FAIL %s done got %b exp %b", e.tag, done, e.dn);
      end
      tests++;
      assert (err === e.er) else begin
        fails++; $error("FAIL %s err got %b exp %b", e.tag, err, e.er);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input string tag, input logic [11:0] pc, input logic [15:0] cnt,
                      input logic run, input logic dn, input logic er);
    push_exp(tag, pc, cnt, run, dn, er);
    tick();
    check_out();
  endtask

  task automatic cfg_wr(input logic sel, input logic [3:0] addr, input logic [11:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    step("cfg_idle", 12'h000, 16'd0, 1'b0, 1'b0, 1'b0);
    cfg_we = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    push_exp("reset", 12'h000, 16'd0, 1'b0, 1'b0, 1'b0);
    check_out();

    // Table load while idle
    cfg_wr(1'b1, 4'd1, 12'h040);
    cfg_wr(1'b1, 4'd0, 12'h200);
    cfg_wr(1'b1, 4'd2, 12'hFFF);
    cfg_wr(1'b1, 4'd3, 12'hABC);
    cfg_wr(1'b0, 4'd3, 12'h100);
    cfg_wr(1'b0, 4'd2, 12'hFFE);

    // Start program 1 while overwriting its start entry: old value is used
    start = 1'b1; prog_sel = 2'd1;
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 4'd1; cfg_data = 12'h777;
    step("start_p1", 12'h040, 16'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0; cfg_we = 1'b0;

    step("inc1", 12'h041, 16'd1, 1'b1, 1'b0, 1'b0);
    step("inc2", 12'h042, 16'd2, 1'b1, 1'b0, 1'b0);
    start = 1'b1; prog_sel = 2'd0;
    step("inc3_start_ignored", 12'h043, 16'd3, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("inc4", 12'h044, 16'd4, 1'b1, 1'b0, 1'b0);
    step("inc5", 12'h045, 16'd5, 1'b1, 1'b0, 1'b0);

    // Absolute branch while rewriting the same LUT entry: old target used
    branch_taken = 1'b1; branch_rel = 1'b0; target_idx = 4'd3;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd3; cfg_data = 12'h300;
    step("br_abs", 12'h100, 16'd6, 1'b1, 1'b0, 1'b0);
    cfg_we = 1'b0;

    branch_rel = 1'b1; target_idx = 4'd2;
    step("br_rel_neg", 12'h0FE, 16'd7, 1'b1, 1'b0, 1'b0);

    // Stall beats a pending branch
    stall = 1'b1; branch_rel = 1'b0; target_idx = 4'd3;
    for (int i = 0; i < 3; i++) step("stall", 12'h0FE, 16'd7, 1'b1, 1'b0, 1'b0);

    // Halt beats stall; start held high must not retrigger
    halt = 1'b1; start = 1'b1; prog_sel = 2'd0;
    step("halt_stall", 12'h0FE, 16'd8, 1'b0, 1'b1, 1'b0);
    halt = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    step("done_hold1", 12'h0FE, 16'd8, 1'b0, 1'b1, 1'b0);
    step("done_hold2", 12'h0FE, 16'd8, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    step("done_to_idle", 12'h0FE, 16'd8, 1'b0, 1'b1, 1'b0);

    start = 1'b1; prog_sel = 2'd0;
    step("start_p0", 12'h200, 16'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    halt = 1'b1;
    step("halt_first", 12'h200, 16'd1, 1'b0, 1'b1, 1'b0);
    halt = 1'b0;
    step("to_idle", 12'h200, 16'd1, 1'b0, 1'b1, 1'b0);

    // Run-only controls are ignored in IDLE
    halt = 1'b1; stall = 1'b1; branch_taken = 1'b1;
    step("idle_ignore", 12'h200, 16'd1, 1'b0, 1'b1, 1'b0);
    halt = 1'b0; stall = 1'b0; branch_taken = 1'b0;

    // Out-of-range program select
    start = 1'b1; prog_sel = 2'd3;
    step("bad_prog_err", 12'h200, 16'd1, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    step("err_clears", 12'h200, 16'd1, 1'b0, 1'b1, 1'b0);

    // PC wrap
    start = 1'b1; prog_sel = 2'd2;
    step("start_p2", 12'hFFF, 16'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("pc_wrap", 12'h000, 16'd1, 1'b1, 1'b0, 1'b0);

    // Counter saturation
    repeat (65533) @(posedge clock);
    #1;
    step("cnt_reach_max", 12'hFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step("cnt_saturated", 12'hFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Config write during RUN, then branch to 0x123
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd5; cfg_data = 12'h123;
    step("cfg_in_run", 12'h000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    cfg_we = 1'b0;
    branch_taken = 1'b1; branch_rel = 1'b0; target_idx = 4'd5;
    step("br_to_123", 12'h123, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b0;

    // Asynchronous reset mid-run
    #2;
    reset = 1'b1;
    #1;
    push_exp("async_reset", 12'h000, 16'd0, 1'b0, 1'b0, 1'b0);
    check_out();
    @(posedge clock);
    #1;
    reset = 1'b0;
    push_exp("post_reset", 12'h000, 16'd0, 1'b0, 1'b0, 1'b0);
    check_out();

    // Tables cleared by reset
    start = 1'b1; prog_sel = 2'd1;
    step("start_cleared", 12'h000, 16'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("inc_after_rst", 12'h001, 16'd1, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b1; branch_rel = 1'b0; target_idx = 4'd3;
    step("lut_cleared_abs", 12'h000, 16'd2, 1'b1, 1'b0, 1'b0);
    step("inc_again", 12'h000, 16'd3, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b0;
    step("inc_after_br", 12'h001, 16'd4, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b1; branch_rel = 1'b1; target_idx = 4'd5;
    step("lut_cleared_rel", 12'h001, 16'd5, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b0;

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the single-program program counter. Sequences instruction fetch addresses for one of NUM_PROGS programs, chosen at start, with a start/done handshake. Supports stall, halt, and absolute or PC-relative branches whose targets come from a writable jump lookup table. Drives the instruction memory address and tells the top level when a program has finished and how many instructions it retired.

Parameters:
PC_BITS, 12, width of the fetch address and of every table entry
NUM_PROGS, 3, number of selectable programs (entries in the start-address table)
LUT_DEPTH, 16, number of jump-target entries
CNT_BITS, 16, width of the retired-instruction counter

Ports:
clock  input  1  system clock, all state updates on its rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  level request to begin the program selected by prog_sel
prog_sel  input  $clog2(NUM_PROGS) (min 1)  program index, sampled with start
stall  input  1  hold the PC this cycle (RUN only)
halt  input  1  current instruction is the program's last; finish
branch_taken  input  1  take a branch this cycle
branch_rel  input  1  1 = PC-relative branch, 0 = absolute
target_idx  input  $clog2(LUT_DEPTH)  jump-LUT index for the branch
cfg_we  input  1  table write enable
cfg_sel  input  1  0 = jump LUT, 1 = start-address table
cfg_addr  input  $clog2(LUT_DEPTH)  table write index
cfg_data  input  PC_BITS  table write data
pc_out  output  PC_BITS  current fetch address
running  output  1  high while in RUN
done  output  1  high from halt until the next accepted start
err  output  1  one-cycle pulse when start is refused
instr_count  output  CNT_BITS  instructions retired in the current or last run

Behaviour:
- Reset state, asynchronous: FSM IDLE, pc_out=0, running=0, done=0, err=0, instr_count=0, every table entry 0.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - start=1 and prog_sel<NUM_PROGS: next cycle pc_out=start_tab[prog_sel], state RUN, running=1, done=0, instr_count=0.
  - start=1 and prog_sel>=NUM_PROGS: stay in IDLE, err=1 for one cycle, other outputs unchanged.
- RUN, one action per cycle, priority halt > stall > branch > increment:
  - halt: state DONE, pc_out held, running=0, done=1, instr_count+1.
  - stall: pc_out and instr_count held.
  - branch_taken, branch_rel=0: pc_out=lut[target_idx].
  - branch_taken, branch_rel=1: pc_out=pc_out + lut[target_idx], entry treated as two's-complement PC_BITS, result mod 2^PC_BITS.
  - Otherwise: pc_out=pc_out+1, wrapping from 2^PC_BITS-1 to 0 with no flag.
  - Every non-stall cycle, branch or increment, adds 1 to instr_count.
- instr_count saturates at 2^CNT_BITS-1.
- start while in RUN is ignored; there is no restart mid-program.
- DONE: pc_out held, done=1. When start=0, go to IDLE with done still 1. start held high through DONE does not retrigger; start must be seen low first.
- stall, halt and branch inputs are ignored outside RUN.
- Config writes are accepted in any state and take effect the next cycle. A branch or start in the same cycle as a write to the entry it reads uses the old value.
- cfg_sel=1 writes with cfg_addr>=NUM_PROGS are dropped. cfg_sel=0 writes index the jump LUT directly.
- Reset mid-run aborts immediately to the reset state. Tables are cleared and must be reloaded.
- pc_out is registered: the new address is visible the cycle after the event, so fetch latency is 1 cycle.

Decomposition:
- Package definitions:
  - seq_state_t enum {IDLE, RUN, DONE}
  - constants CFG_SEL_LUT=1'b0, CFG_SEL_START=1'b1
- Sub-module pc_target_lut holds both tables: LUT_DEPTH x PC_BITS and NUM_PROGS x PC_BITS, with a synchronous write port and two combinational read ports (jump read, start read).
- pc_sequencer holds the FSM, next-PC mux/adder and counter.

Test Plan:
- Load start_tab[1]=0x040, pulse start with prog_sel=1, no branch/stall for 5 cycles -> pc_out 0x040, 0x041 … 0x045; instr_count=5.
- lut[3]=0x100; branch_taken=1, branch_rel=0, target_idx=3 at pc 0x045 -> pc_out=0x100. Then lut[2]=0xFFE, relative branch idx 2 at pc 0x100 -> pc_out=0x0FE.
- stall high 3 cycles in RUN -> pc_out and instr_count frozen. stall and halt together -> DONE, done=1, running=0.
- Hold start high through halt -> no restart. Drop start, raise it with prog_sel=0 -> pc_out=start_tab[0], done=0, instr_count=0.
- prog_sel=3 with NUM_PROGS=3 -> err pulses 1 cycle, state IDLE. pc_out=0xFFF plus increment -> pc_out=0x000.
- Assert reset mid-run at pc 0x123 -> pc_out=0, running=0, done=0, tables read 0 afterwards.
